// File: rtl/multi_channel_timer_if.sv
// Control/status bundle between multi_channel_timer and the register/interrupt fabric.
// The timer side uses the slave modport; the driving side uses master.
interface multi_channel_timer_if #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
);
    logic [2*NUM_CH-1:0]     mode_sel;
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH*WIDTH-1:0] load_value;
    logic [NUM_CH*WIDTH-1:0] duty_cycle;
    logic [PRESC_W-1:0]      prescale;
    logic [NUM_CH-1:0]       irq_clr;
    logic [NUM_CH-1:0]       pwm_out;
    logic [NUM_CH-1:0]       irq;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH*WIDTH-1:0] count_out;

    modport master (
        output mode_sel, start, load_value, duty_cycle, prescale, irq_clr,
        input  pwm_out, irq, busy, count_out
    );

    modport slave (
        input  mode_sel, start, load_value, duty_cycle, prescale, irq_clr,
        output pwm_out, irq, busy, count_out
    );
endinterface

// File: rtl/multi_channel_timer.sv
// NUM_CH independent HOLD/ONE-SHOT/PERIODIC/PWM timers sharing one prescale value.
// Define MULTI_CHANNEL_TIMER_STICKY_IRQ_EN to make irq sticky until irq_clr.
module multi_channel_timer #(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic                  divided_clk,
    input  logic                  rst,
    multi_channel_timer_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ONE  = 2'b01;

`ifndef MULTI_CHANNEL_TIMER_STICKY_IRQ_EN
    logic unused_irq_clr;
    assign unused_irq_clr = ^bus.irq_clr;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state_q, state_d;
        logic [WIDTH-1:0]   count_q, count_d;
        logic [WIDTH-1:0]   load_q, load_d, duty_q, duty_d;
        logic [1:0]         mode_q, mode_d;
        logic [PRESC_W-1:0] presc_q, presc_d;
        logic               start_q, rise_q, pwm_q, pwm_d;
        logic               tick, term;
        logic [WIDTH-1:0]   load_in, duty_in;
        logic [1:0]         mode_in;

        assign load_in = bus.load_value[WIDTH*i +: WIDTH];
        assign duty_in = bus.duty_cycle[WIDTH*i +: WIDTH];
        assign mode_in = bus.mode_sel[2*i +: 2];

        // Terminal is suppressed when the run is being aborted by reset or start=0
        assign tick = (state_q == ST_RUN) && (presc_q == bus.prescale);
        assign term = tick && bus.start[i] && !rst && (load_q != '0)
                      && (count_q == load_q - WIDTH'(1));

        always_comb begin
            state_d = state_q;
            count_d = count_q;
            load_d  = load_q;
            duty_d  = duty_q;
            mode_d  = mode_q;
            presc_d = presc_q;
            case (state_q)
                ST_IDLE: begin
                    if (rise_q && bus.start[i] && (load_in != '0) && (mode_in != MODE_HOLD)) begin
                        state_d = ST_RUN;
                        count_d = '0;
                        presc_d = '0;
                        load_d  = load_in;
                        duty_d  = duty_in;
                        mode_d  = mode_in;
                    end
                end
                ST_RUN: begin
                    if (!bus.start[i]) begin
                        state_d = ST_IDLE;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
                        if (term) begin
                            if (mode_q == MODE_ONE) begin
                                state_d = ST_DONE;
                            end else begin
                                // Period boundary: pick up new period/duty glitch-free
                                count_d = '0;
                                load_d  = load_in;
                                duty_d  = duty_in;
                            end
                        end else if (tick) begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.start[i]) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            pwm_d = (state_d == ST_RUN) && (count_d < duty_d);
        end

        always_ff @(posedge divided_clk) begin
            start_q <= bus.start[i];
            load_q  <= load_d;
            duty_q  <= duty_d;
            mode_q  <= mode_d;
        end

        always_ff @(posedge divided_clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                count_q <= '0;
                presc_q <= '0;
                rise_q  <= 1'b0;
                pwm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                presc_q <= presc_d;
                rise_q  <= bus.start[i] & ~start_q;
                pwm_q   <= pwm_d;
            end
        end

`ifdef MULTI_CHANNEL_TIMER_STICKY_IRQ_EN
        logic sticky_q;
        always_ff @(posedge divided_clk) begin
            if (rst)                  sticky_q <= 1'b0;
            else if (term)            sticky_q <= 1'b1;
            else if (bus.irq_clr[i])  sticky_q <= 1'b0;
        end
        assign bus.irq[i] = sticky_q | term;
`else
        assign bus.irq[i] = term;
`endif

        assign bus.busy[i]                    = (state_q == ST_RUN);
        assign bus.pwm_out[i]                 = pwm_q;
        assign bus.count_out[WIDTH*i +: WIDTH] = count_q;
    end
endmodule
